// File: rtl/sfx_scheduler.sv
// Four-clip sound-effect scheduler: arbitrates clip requests and streams 16-bit samples from a shared ROM to the DAC.
// Optional feature macro: SFX_SCHEDULER_PREEMPT_EN (a higher clip id preempts the clip being played).

module sfx_scheduler #(
  parameter int CLIP_WORDS = 2048,
  parameter int REPEAT     = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic        audio_out_allowed,
  input  logic [31:0] rom_q,
  output logic [12:0] rom_addr,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic        write_audio_out,
  output logic        busy,
  output logic [1:0]  cur_sfx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [11:0] LAST_WORD = 12'(CLIP_WORDS - 1);
  localparam logic [1:0]  LAST_REP  = 2'(REPEAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [12:0] rom_addr_q, rom_addr_d;
  logic [1:0]  cur_sfx_q, cur_sfx_d;
  logic [11:0] word_cnt_q, word_cnt_d;
  logic [1:0]  rep_cnt_q, rep_cnt_d;
  logic        half_q, half_d;          // 1 = upper half of the word
  logic        fetch_cnt_q, fetch_cnt_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  grant_idx_s;
  logic        load_s;
  logic        preempt_s;
  logic        write_s;
  logic [15:0] sample_s;

  function automatic logic [1:0] top_index(input logic [3:0] vec);
    logic [1:0] idx;
    if (vec[3]) begin
      idx = 2'd3;
    end else if (vec[2]) begin
      idx = 2'd2;
    end else if (vec[1]) begin
      idx = 2'd1;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

  assign grant_idx_s = top_index(pending_q);

`ifdef SFX_SCHEDULER_PREEMPT_EN
  assign preempt_s = ((state_q == FETCH) || (state_q == PLAY)) &&
                     (pending_q != 4'b0000) && (grant_idx_s > cur_sfx_q);
`else
  assign preempt_s = 1'b0;
`endif

  // Next-state, counter and strobe logic; a grant (or preemption) reloads the whole clip context.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | req;
    rom_addr_d  = rom_addr_q;
    cur_sfx_d   = cur_sfx_q;
    word_cnt_d  = word_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    half_d      = half_q;
    fetch_cnt_d = fetch_cnt_q;
    word_d      = word_q;
    load_s      = 1'b0;
    write_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q != 4'b0000) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      FETCH: begin
        if (preempt_s) begin
          load_s = 1'b1;
        end else if (fetch_cnt_q) begin
          word_d      = rom_q;
          half_d      = 1'b1;
          rep_cnt_d   = 2'd0;
          fetch_cnt_d = 1'b0;
          state_d     = PLAY;
        end else begin
          fetch_cnt_d = 1'b1;
        end
      end
      PLAY: begin
        if (preempt_s) begin
          load_s = 1'b1;
        end else if (audio_out_allowed) begin
          write_s = 1'b1;
          if (rep_cnt_q != LAST_REP) begin
            rep_cnt_d = rep_cnt_q + 2'd1;
          end else if (half_q) begin
            rep_cnt_d = 2'd0;
            half_d    = 1'b0;
          end else begin
            rep_cnt_d  = 2'd0;
            half_d     = 1'b1;
            word_cnt_d = word_cnt_q + 12'd1;
            rom_addr_d = rom_addr_q + 13'd1;
            if (word_cnt_q == LAST_WORD) begin
              state_d = DONE;
            end else begin
              state_d = FETCH;
            end
          end
        end else begin
          write_s = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_s) begin
      state_d     = FETCH;
      pending_d   = (pending_q & ~(4'b0001 << grant_idx_s)) | req;
      rom_addr_d  = {grant_idx_s, 11'd0};
      cur_sfx_d   = grant_idx_s;
      word_cnt_d  = 12'd0;
      rep_cnt_d   = 2'd0;
      half_d      = 1'b1;
      fetch_cnt_d = 1'b0;
    end else begin
      pending_d = pending_q | req;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= 4'b0000;
      rom_addr_q  <= 13'd0;
      cur_sfx_q   <= 2'd0;
      word_cnt_q  <= 12'd0;
      rep_cnt_q   <= 2'd0;
      half_q      <= 1'b1;
      fetch_cnt_q <= 1'b0;
      word_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rom_addr_q  <= rom_addr_d;
      cur_sfx_q   <= cur_sfx_d;
      word_cnt_q  <= word_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      half_q      <= half_d;
      fetch_cnt_q <= fetch_cnt_d;
      word_q      <= word_d;
    end
  end

  assign sample_s                = half_q ? word_q[31:16] : word_q[15:0];
  assign left_channel_audio_out  = (state_q == PLAY) ? {sample_s, 16'h0000} : 32'h0000_0000;
  assign right_channel_audio_out = left_channel_audio_out;
  assign write_audio_out         = write_s;
  assign busy                    = (state_q != IDLE);
  assign rom_addr                = rom_addr_q;
  assign cur_sfx                 = cur_sfx_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed self-checking bench for sfx_scheduler (default build, preemption disabled).

module tb_sfx_scheduler;

  localparam int CW          = 2048;
  localparam int REP         = 2;
  localparam int CLIP_WRITES = CW * 2 * REP;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic        audio_out_allowed = 1'b0;
  logic [31:0] rom_q = 32'd0;
  logic [12:0] rom_addr;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        write_audio_out;
  logic        busy;
  logic [1:0]  cur_sfx;

  int compared   = 0;
  int mismatched = 0;

  sfx_scheduler #(.CLIP_WORDS(CW), .REPEAT(REP)) dut (
    .CLOCK_50               (CLOCK_50),
    .reset                  (reset),
    .req                    (req),
    .audio_out_allowed      (audio_out_allowed),
    .rom_q                  (rom_q),
    .rom_addr               (rom_addr),
    .left_channel_audio_out (left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .write_audio_out        (write_audio_out),
    .busy                   (busy),
    .cur_sfx                (cur_sfx)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [31:0] rom_word(input logic [12:0] a);
    if (a == 13'd0) return 32'h1234_5678;
    else return {3'b000, a, 3'b101, a};
  endfunction

  // Registered ROM with one-cycle read latency
  always @(posedge CLOCK_50) rom_q <= rom_word(rom_addr);

  function automatic logic [31:0] exp_sample(input logic [12:0] base, input int k);
    logic [31:0] w;
    w = rom_word(base + 13'(k / (2 * REP)));
    if (((k / REP) % 2) == 0) return {w[31:16], 16'h0000};
    else return {w[15:0], 16'h0000};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic settle();
    @(negedge CLOCK_50);
  endtask

  // Entered on the first FETCH cycle of a clip; follows it until the scheduler is idle again.
  task automatic play_clip(input string tag, input logic [1:0] sfx, input int k0,
                           input bit toggle, input int inj_cycle, input logic [3:0] inj_req);
    logic [12:0] base;
    logic [31:0] exp;
    int writes;
    int bad;
    int bad_allow;
    bit done;
    base = {sfx, 11'd0};
    writes = k0;
    bad = 0;
    bad_allow = 0;
    done = 1'b0;
    for (int c = 0; c < 30000 && !done; c++) begin
      if (write_audio_out === 1'b1) begin
        if (audio_out_allowed !== 1'b1) bad_allow++;
        exp = exp_sample(base, writes);
        if (left_channel_audio_out !== exp || right_channel_audio_out !== exp ||
            rom_addr !== base + 13'(writes / (2 * REP)) || cur_sfx !== sfx) bad++;
        writes++;
      end else if (busy === 1'b0) begin
        done = 1'b1;
      end
      if (!done) begin
        cyc();
        req = (c == inj_cycle) ? inj_req : 4'b0000;
        if (toggle) audio_out_allowed = ~audio_out_allowed;
        settle();
      end
    end
    check({tag, " finished"}, 32'(done), 32'd1);
    check({tag, " writes"}, 32'(writes), 32'(CLIP_WRITES));
    check({tag, " bad samples"}, 32'(bad), 32'd0);
    check({tag, " writes while disallowed"}, 32'(bad_allow), 32'd0);
  endtask

  initial begin
    int w;
    int busy_seen;

    // Reset state
    repeat (3) cyc();
    cyc(); reset = 1'b0; settle();
    check("rst busy", 32'(busy), 32'd0);
    check("rst write", 32'(write_audio_out), 32'd0);
    check("rst rom_addr", 32'(rom_addr), 32'd0);
    check("rst cur_sfx", 32'(cur_sfx), 32'd0);
    check("rst left", left_channel_audio_out, 32'd0);
    check("rst right", right_channel_audio_out, 32'd0);

    // Request coincident with reset is ignored
    cyc(); reset = 1'b1; req = 4'b1000; settle();
    cyc(); reset = 1'b0; req = 4'b0000; settle();
    cyc(); settle();
    check("req during reset ignored", 32'(busy), 32'd0);

    // Clip 0, latency and first-word sample order, then full clip
    audio_out_allowed = 1'b1;
    cyc(); req = 4'b0001; settle();
    cyc(); req = 4'b0000; settle();
    check("N+1 still idle", 32'(busy), 32'd0);
    cyc(); settle();
    check("N+2 busy", 32'(busy), 32'd1);
    check("N+2 rom_addr", 32'(rom_addr), 32'd0);
    check("N+2 cur_sfx", 32'(cur_sfx), 32'd0);
    check("N+2 write", 32'(write_audio_out), 32'd0);
    check("N+2 left", left_channel_audio_out, 32'd0);
    cyc(); settle();
    check("N+3 write", 32'(write_audio_out), 32'd0);
    cyc(); settle();
    check("N+4 write", 32'(write_audio_out), 32'd1);
    check("N+4 left", left_channel_audio_out, 32'h1234_0000);
    check("N+4 right", right_channel_audio_out, 32'h1234_0000);
    cyc(); settle();
    check("N+5 write", 32'(write_audio_out), 32'd1);
    check("N+5 left", left_channel_audio_out, 32'h1234_0000);
    cyc(); settle();
    check("N+6 left", left_channel_audio_out, 32'h5678_0000);
    check("N+6 right", right_channel_audio_out, 32'h5678_0000);
    cyc(); settle();
    check("N+7 left", left_channel_audio_out, 32'h5678_0000);
    cyc(); settle();
    check("N+8 write", 32'(write_audio_out), 32'd0);
    check("N+8 rom_addr", 32'(rom_addr), 32'd1);
    play_clip("clip0", 2'd0, 4, 1'b0, -1, 4'b0000);
    check("clip0 end cur_sfx", 32'(cur_sfx), 32'd0);
    check("clip0 end rom_addr", 32'(rom_addr), 32'd2048);
    check("clip0 end left", left_channel_audio_out, 32'd0);

    // Two simultaneous requests: clip 2 first, then clip 0
    cyc(); req = 4'b0101; settle();
    cyc(); req = 4'b0000; settle();
    cyc(); settle();
    check("pri clip2 rom_addr", 32'(rom_addr), 32'd4096);
    check("pri clip2 cur_sfx", 32'(cur_sfx), 32'd2);
    play_clip("clip2", 2'd2, 0, 1'b0, -1, 4'b0000);
    cyc(); settle();
    check("pri clip0 busy", 32'(busy), 32'd1);
    check("pri clip0 rom_addr", 32'(rom_addr), 32'd0);
    check("pri clip0 cur_sfx", 32'(cur_sfx), 32'd0);
    play_clip("clip0 second", 2'd0, 0, 1'b0, -1, 4'b0000);

    // Flow control toggling every cycle on clip 1
    cyc(); req = 4'b0010; settle();
    cyc(); req = 4'b0000; settle();
    cyc(); settle();
    check("toggle rom_addr", 32'(rom_addr), 32'd2048);
    play_clip("toggle clip1", 2'd1, 0, 1'b1, -1, 4'b0000);
    audio_out_allowed = 1'b1;
    check("toggle cur_sfx held", 32'(cur_sfx), 32'd1);
    check("toggle end rom_addr", 32'(rom_addr), 32'd4096);

    // Higher request during clip 1 waits for clip 1 to finish
    cyc(); req = 4'b0010; settle();
    cyc(); req = 4'b0000; settle();
    cyc(); settle();
    check("nopre clip1 cur_sfx", 32'(cur_sfx), 32'd1);
    play_clip("clip1 no preempt", 2'd1, 0, 1'b0, 40, 4'b1000);
    cyc(); settle();
    check("nopre clip3 rom_addr", 32'(rom_addr), 32'd6144);
    check("nopre clip3 cur_sfx", 32'(cur_sfx), 32'd3);
    check("nopre clip3 busy", 32'(busy), 32'd1);
    cyc(); reset = 1'b1; settle();
    cyc(); reset = 1'b0; settle();
    check("nopre abort busy", 32'(busy), 32'd0);

    // Reset at write 100 with a pending request
    cyc(); req = 4'b0001; settle();
    cyc(); req = 4'b0000; settle();
    cyc(); settle();
    w = 0;
    for (int c = 0; c < 1000 && w < 100; c++) begin
      cyc();
      req = (c == 5) ? 4'b1000 : 4'b0000;
      settle();
      if (write_audio_out === 1'b1) w++;
    end
    check("reached write 100", 32'(w), 32'd100);
    cyc(); req = 4'b0000; reset = 1'b1; settle();
    cyc(); reset = 1'b0; settle();
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset write", 32'(write_audio_out), 32'd0);
    check("midreset rom_addr", 32'(rom_addr), 32'd0);
    check("midreset cur_sfx", 32'(cur_sfx), 32'd0);
    check("midreset left", left_channel_audio_out, 32'd0);
    busy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(); settle();
      if (busy !== 1'b0) busy_seen++;
    end
    check("pending discarded", 32'(busy_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sfx_scheduler.md
SFX_SCHEDULER -- requirements
Module: sfx_scheduler

Interface
REQ-001 Parameter CLIP_WORDS, default 2048, 32-bit ROM words per clip; legal range 2..2048.
REQ-002 Parameter REPEAT, default 2, DAC writes per 16-bit sample; legal range 1..4.
REQ-003 Port CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port req  in  4  one-cycle sound-effect request pulses; bit i = clip i; bit 3 has highest priority.
REQ-006 Port audio_out_allowed  in  1  audio controller FIFO has space.
REQ-007 Port rom_q  in  32  shared sound ROM data; registered, 1-cycle read latency.
REQ-008 Port rom_addr  out  13  shared sound ROM address.
REQ-009 Port left_channel_audio_out  out  32  left sample.
REQ-010 Port right_channel_audio_out  out  32  right sample; always equal to left.
REQ-011 Port write_audio_out  out  1  one-cycle DAC write strobe.
REQ-012 Port busy  out  1  high in every state except IDLE.
REQ-013 Port cur_sfx  out  2  id of the clip being played; holds its last value in IDLE.

Function
REQ-014 A 4-bit pending register shall set bit i on any cycle in which req[i]=1.
REQ-015 The FSM shall have exactly four states: IDLE, FETCH, PLAY, DONE.
REQ-016 In IDLE with pending nonzero, the FSM shall grant the highest set index g and clear pending[g].
REQ-017 On grant, the next state shall be FETCH, with rom_addr = g*2048, cur_sfx = g and word count = 0.
REQ-018 If req[g] is high in the grant cycle, pending[g] shall remain set, so the clip replays afterwards.
REQ-019 FETCH shall last exactly 2 cycles, then latch rom_q into a word register and enter PLAY with half = upper.
REQ-020 In PLAY, the current sample shall be word[31:16] when half = upper and word[15:0] when half = lower.
REQ-021 Both audio outputs shall equal {sample, 16'b0} while in PLAY and shall be 0 in all other states.
REQ-022 In PLAY, write_audio_out shall be 1 for exactly one cycle per audio_out_allowed=1 cycle, and 0 otherwise.
REQ-023 Each write shall increment a repeat count; after REPEAT writes, the count shall clear and half shall advance.
REQ-024 After the lower half's final write, the word count shall increment and rom_addr shall increment (mod 2^13); the FSM shall then enter FETCH, or enter DONE if word count reaches CLIP_WORDS.
REQ-025 A clip shall therefore produce exactly CLIP_WORDS*2*REPEAT writes.
REQ-026 DONE shall last 1 cycle with write_audio_out=0, then enter IDLE, where arbitration resumes the next cycle.
REQ-027 With audio_out_allowed held low, PLAY shall hold all state indefinitely and issue no write.
REQ-028 Requests arriving while busy shall only set pending bits, except as given in REQ-034.
REQ-029 Minimum latency: req at cycle N; pending set at N+1; FETCH at N+2; PLAY at N+4; first write at N+4 if audio_out_allowed=1.

Reset
REQ-030 Reset shall clear pending, the word/repeat counters and half, and shall force state IDLE.
REQ-031 Reset shall also force rom_addr=0, cur_sfx=0, busy=0, write_audio_out=0 and audio outputs=0.
REQ-032 Reset asserted mid-clip shall abort playback within one cycle and discard all pending requests.
REQ-033 A req pulse coincident with reset shall be ignored.

Configuration
REQ-034 With SFX_SCHEDULER_PREEMPT_EN defined, a pending index greater than cur_sfx in FETCH or PLAY shall preempt the current clip.
REQ-035 Preemption shall abort the current clip without a write in that cycle, grant the new clip as in REQ-016/017, and discard the aborted clip.
REQ-036 Without SFX_SCHEDULER_PREEMPT_EN, clips shall always play to completion, and preemption logic shall be absent.

Verification
REQ-037 Scenario: req=0001, allowed=1 -> rom_addr walks 0..2047; 8192 writes; busy falls after DONE; cur_sfx=0.
REQ-038 Scenario: req=0101 in one cycle -> clip 2 plays first (rom_addr starts 4096), then clip 0 plays (rom_addr starts 0).
REQ-039 Scenario: word 0x12345678, REPEAT=2 -> outputs 0x12340000 twice, then 0x56780000 twice; left equals right.
REQ-040 Scenario: allowed toggled 1/0 each cycle -> writes only on allowed-high cycles; total stays 8192.
REQ-041 Scenario: reset pulsed at write 100 with pending=1000 -> next cycle IDLE, write=0, pending=0; no later playback.
REQ-042 Scenario (PREEMPT_EN on/off): req[3] during clip 1 -> macro on: rom_addr jumps to 6144 within 2 cycles; macro off: clip 1 completes, then clip 3 plays.
